ddr_req_arbiter: RTL and testbench

- Initiator-side master for the single-port DDR request/response protocol.
- Accepts requests from two clients: the instruction-fetch port (I, read-only) and the data port (D, read/write).
- Arbitrates between them round-robin and drives one transaction at a time onto the ddr_* bus.
- Returns read data and a one-cycle completion pulse to the requesting client.

---
 rtl/ddr_req_arbiter_if.sv | 43 ++++
 rtl/ddr_req_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ddr_req_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr_req_arbiter_if
// Description : Single-port DDR request/response bus.
//               master : the initiator, which drives the request and the
//                        latched address/write data
//               slave  : the responder, which returns read data and a
//                        one-cycle ddr_resp
// Signals     : ddr_addr  [31:0]  byte address, forwarded unmodified
//               ddr_read          read request, held until ddr_resp
//               ddr_write         write request, held until ddr_resp
//               ddr_wdata [31:0]  write data
//               ddr_rdata [31:0]  read data, valid in the ddr_resp cycle
//               ddr_resp          completion, one cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr_req_arbiter_if;
   logic [31:0] ddr_addr;
   logic        ddr_read;
   logic        ddr_write;
   logic [31:0] ddr_wdata;
   logic [31:0] ddr_rdata;
   logic        ddr_resp;

   modport master (
      output ddr_addr,
      output ddr_read,
      output ddr_write,
      output ddr_wdata,
      input  ddr_rdata,
      input  ddr_resp
   );

   modport slave (
      input  ddr_addr,
      input  ddr_read,
      input  ddr_write,
      input  ddr_wdata,
      output ddr_rdata,
      output ddr_resp
   );
endinterface
`default_nettype wire

// File: rtl/ddr_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ddr_req_arbiter
// Description : Round-robin arbiter between an instruction-fetch client (I,
//               read-only) and a data client (D, read/write) in front of a
//               single-port DDR request/response bus.  One transaction is in
//               flight at a time; each completion returns a one-cycle resp
//               pulse, plus read data for reads, to the requesting client.
// Ports       : clk, rst_n                 clock, async active-low reset
//               i_addr/i_read              I-port request
//               i_rdata/i_resp             I-port completion
//               d_addr/d_read/d_write/
//               d_wdata                    D-port request
//               d_rdata/d_resp             D-port completion
//               ddr (master modport)       DDR request/response bus
//               ddr_timeout                sticky "ddr_resp overdue" flag
// Parameters  : TIMEOUT_CYCLES  REQ cycles without ddr_resp before
//                               ddr_timeout is raised
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_req_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   // I port
   input  wire logic [31:0] i_addr,
   input  wire logic        i_read,
   output logic      [31:0] i_rdata,
   output logic             i_resp,
   // D port
   input  wire logic [31:0] d_addr,
   input  wire logic        d_read,
   input  wire logic        d_write,
   input  wire logic [31:0] d_wdata,
   output logic      [31:0] d_rdata,
   output logic             d_resp,
   // DDR bus
   ddr_req_arbiter_if.master ddr,
   output logic             ddr_timeout
);

   localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // r_last_d doubles as the grant of the transaction in flight: it is
   // updated at launch, so during REQ it names the current owner and in
   // IDLE it names the client granted last time.
   logic               r_last_d;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
   logic               r_ddr_read;
   logic               r_ddr_write;
   logic [31:0]        r_i_rdata;
   logic [31:0]        r_d_rdata;
   logic               r_i_resp;
   logic               r_d_resp;
   logic               r_timeout;
   logic [c_CNT_W-1:0] r_cnt;

   logic w_i_req;
   logic w_d_req;
   logic w_pick_d;
   logic w_pick_wr;
   logic w_launch;
   logic w_done;
   logic w_wait;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next state, arbitration and transaction strobes
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_done      = 1'b0;
      w_wait      = 1'b0;
      w_i_req     = i_read;
      w_d_req     = d_read | d_write;
      // On a tie the client not served last time wins.
      w_pick_d    = w_d_req & (~w_i_req | ~r_last_d);
      // d_read together with d_write is illegal and resolves to a write.
      w_pick_wr   = w_pick_d & d_write;

      case (r_state)
         S_IDLE: begin
            if (w_i_req || w_d_req) begin
               w_launch    = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (ddr.ddr_resp) begin
               w_done      = 1'b1;
               w_state_nxt = S_GAP;
            end else begin
               w_wait      = 1'b1;
            end
         end
         S_GAP: begin
            // One idle bus cycle so the responder can return to idle.
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registered datapath and outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_d    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_ddr_read  <= 1'b0;
         r_ddr_write <= 1'b0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
         r_i_resp    <= 1'b0;
         r_d_resp    <= 1'b0;
         r_timeout   <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_i_resp <= 1'b0;
         r_d_resp <= 1'b0;

         if (w_launch) begin
            r_last_d    <= w_pick_d;
            r_addr      <= w_pick_d ? d_addr : i_addr;
            r_wdata     <= d_wdata;
            r_ddr_read  <= ~w_pick_wr;
            r_ddr_write <= w_pick_wr;
            r_cnt       <= '0;
         end

         if (w_done) begin
            r_ddr_read  <= 1'b0;
            r_ddr_write <= 1'b0;
            if (r_last_d) begin
               r_d_resp <= 1'b1;
               if (!r_ddr_write) begin
                  r_d_rdata <= ddr.ddr_rdata;
               end
            end else begin
               r_i_resp  <= 1'b1;
               r_i_rdata <= ddr.ddr_rdata;
            end
         end

         // Saturating wait counter; the flag is set on the same edge the
         // count reaches the limit and is only cleared by reset.
         if (w_wait && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == (c_CNT_MAX - 1'b1)) begin
               r_timeout <= 1'b1;
            end
         end
      end
   end

   assign ddr.ddr_addr  = r_addr;
   assign ddr.ddr_wdata = r_wdata;
   assign ddr.ddr_read  = r_ddr_read;
   assign ddr.ddr_write = r_ddr_write;
   assign i_rdata       = r_i_rdata;
   assign i_resp        = r_i_resp;
   assign d_rdata       = r_d_rdata;
   assign d_resp        = r_d_resp;
   assign ddr_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ddr_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_req_arbiter
// Description : Self-checking bench for ddr_req_arbiter.  A transaction-level
//               model (round-robin choice, word memory, response timing
//               rules, timeout rule) predicts every output each cycle; a
//               behavioural DDR responder with a variable latency sits on
//               the bus.  Directed scenarios are followed by a random phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_req_arbiter;

   localparam int c_TIMEOUT = 8;

   logic        clk;
   logic        rst_n;
   logic [31:0] i_addr;
   logic        i_read;
   logic [31:0] i_rdata;
   logic        i_resp;
   logic [31:0] d_addr;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_resp;
   logic        ddr_timeout;

   ddr_req_arbiter_if ddr_bus ();

   ddr_req_arbiter #(
      .TIMEOUT_CYCLES (c_TIMEOUT)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_addr      (i_addr),
      .i_read      (i_read),
      .i_rdata     (i_rdata),
      .i_resp      (i_resp),
      .d_addr      (d_addr),
      .d_read      (d_read),
      .d_write     (d_write),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_resp      (d_resp),
      .ddr         (ddr_bus.master),
      .ddr_timeout (ddr_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fails  = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- model state ----------------
   logic [31:0] mem_model [64];
   logic [31:0] mem_resp  [64];
   bit          m_busy, m_gap, m_last_d, m_exp_to;
   bit          t_d, t_wr;
   logic [31:0] t_addr, t_wdata;
   int          req_cycles;
   logic [31:0] exp_i_rdata, exp_d_rdata;
   logic [31:0] q_launch [$];

   // stimulus / responder controls
   bit rand_en, spur_en, hold_mode, i_again, d_again, rsp_busy;
   int lat_min, lat_max, rsp_wait;

   task automatic model_reset();
      m_busy = 0; m_gap = 0; m_last_d = 0; m_exp_to = 0;
      exp_i_rdata = '0; exp_d_rdata = '0;
      i_read = 0; d_read = 0; d_write = 0;
      i_again = 0; d_again = 0; rsp_busy = 0;
      ddr_bus.ddr_resp = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_ddr_read"},  32'(ddr_bus.ddr_read),  32'h0);
      check_val({tag, "_ddr_write"}, 32'(ddr_bus.ddr_write), 32'h0);
      check_val({tag, "_ddr_addr"},  ddr_bus.ddr_addr,       32'h0);
      check_val({tag, "_ddr_wdata"}, ddr_bus.ddr_wdata,      32'h0);
      check_val({tag, "_i_resp"},    32'(i_resp),            32'h0);
      check_val({tag, "_d_resp"},    32'(d_resp),            32'h0);
      check_val({tag, "_i_rdata"},   i_rdata,                32'h0);
      check_val({tag, "_d_rdata"},   d_rdata,                32'h0);
      check_val({tag, "_timeout"},   32'(ddr_timeout),       32'h0);
   endtask

   // One clock: check what the last posedge produced, then drive the
   // responder and the clients for the next one.
   task automatic step();
      bit i_req, d_req;
      @(negedge clk);
      if (m_gap) begin
         check_val("gap_ddr_read",  32'(ddr_bus.ddr_read),  32'h0);
         check_val("gap_ddr_write", 32'(ddr_bus.ddr_write), 32'h0);
         check_val("gap_i_resp",    32'(i_resp),            32'h0);
         check_val("gap_d_resp",    32'(d_resp),            32'h0);
         m_gap = 0;
      end else if (m_busy) begin
         if (ddr_bus.ddr_resp) begin
            check_val("done_ddr_read",  32'(ddr_bus.ddr_read),  32'h0);
            check_val("done_ddr_write", 32'(ddr_bus.ddr_write), 32'h0);
            check_val("done_i_resp",    32'(i_resp),            32'(!t_d));
            check_val("done_d_resp",    32'(d_resp),            32'(t_d));
            if (!t_wr) begin
               if (t_d) exp_d_rdata = mem_model[t_addr[7:2]];
               else     exp_i_rdata = mem_model[t_addr[7:2]];
            end else begin
               mem_model[t_addr[7:2]] = t_wdata;
            end
            m_last_d = t_d;
            m_busy   = 0;
            m_gap    = 1;
         end else begin
            check_val("req_ddr_read",  32'(ddr_bus.ddr_read),  32'(!t_wr));
            check_val("req_ddr_write", 32'(ddr_bus.ddr_write), 32'(t_wr));
            check_val("req_ddr_addr",  ddr_bus.ddr_addr,       t_addr);
            if (t_wr) check_val("req_ddr_wdata", ddr_bus.ddr_wdata, t_wdata);
            check_val("req_i_resp", 32'(i_resp), 32'h0);
            check_val("req_d_resp", 32'(d_resp), 32'h0);
            req_cycles++;
            if (req_cycles >= c_TIMEOUT) m_exp_to = 1;
         end
      end else begin
         // Idle: the client inputs held over the past cycle were sampled.
         i_req = i_read;
         d_req = d_read | d_write;
         if (i_req || d_req) begin
            t_d        = d_req && (!i_req || !m_last_d);
            t_wr       = t_d && d_write;
            t_addr     = t_d ? d_addr : i_addr;
            t_wdata    = d_wdata;
            m_busy     = 1;
            req_cycles = 0;
            q_launch.push_back(t_addr);
            check_val("launch_ddr_read",  32'(ddr_bus.ddr_read),  32'(!t_wr));
            check_val("launch_ddr_write", 32'(ddr_bus.ddr_write), 32'(t_wr));
            check_val("launch_ddr_addr",  ddr_bus.ddr_addr,       t_addr);
            if (t_wr) check_val("launch_ddr_wdata", ddr_bus.ddr_wdata, t_wdata);
         end else begin
            check_val("idle_ddr_read",  32'(ddr_bus.ddr_read),  32'h0);
            check_val("idle_ddr_write", 32'(ddr_bus.ddr_write), 32'h0);
         end
         check_val("idle_i_resp", 32'(i_resp), 32'h0);
         check_val("idle_d_resp", 32'(d_resp), 32'h0);
      end
      check_val("i_rdata",     i_rdata,           exp_i_rdata);
      check_val("d_rdata",     d_rdata,           exp_d_rdata);
      check_val("ddr_timeout", 32'(ddr_timeout),  32'(m_exp_to));

      // ---- DDR responder ----
      if (ddr_bus.ddr_resp) begin
         ddr_bus.ddr_resp = 1'b0;
      end else if (ddr_bus.ddr_read || ddr_bus.ddr_write) begin
         if (!rsp_busy) begin
            rsp_busy = 1;
            rsp_wait = $urandom_range(lat_max, lat_min);
         end
         if (rsp_wait == 0) begin
            ddr_bus.ddr_resp = 1'b1;
            rsp_busy         = 0;
            if (ddr_bus.ddr_write) begin
               mem_resp[ddr_bus.ddr_addr[7:2]] = ddr_bus.ddr_wdata;
               ddr_bus.ddr_rdata = $urandom;
            end else begin
               ddr_bus.ddr_rdata = mem_resp[ddr_bus.ddr_addr[7:2]];
            end
         end else begin
            rsp_wait--;
         end
      end else if (spur_en && ($urandom_range(15, 0) == 0)) begin
         ddr_bus.ddr_resp  = 1'b1;
         ddr_bus.ddr_rdata = $urandom;
      end

      // ---- I client ----
      if (i_resp) begin
         i_read  = 0;
         i_again = hold_mode;
      end else if (i_again) begin
         i_read  = 1;
         i_again = 0;
      end else if (rand_en && !i_read && ($urandom_range(3, 0) == 0)) begin
         i_read = 1;
         i_addr = $urandom;
      end
      if (rand_en && m_busy && !t_d) i_addr = $urandom;

      // ---- D client ----
      if (d_resp) begin
         d_again = hold_mode && d_read;
         d_read  = 0;
         d_write = 0;
      end else if (d_again) begin
         d_read  = 1;
         d_again = 0;
      end else if (rand_en && !d_read && !d_write && ($urandom_range(2, 0) == 0)) begin
         case ($urandom_range(7, 0))
            0, 1, 2, 3: d_read  = 1;
            4, 5, 6:    d_write = 1;
            default: begin d_read = 1; d_write = 1; end
         endcase
         d_addr  = $urandom;
         d_wdata = $urandom;
      end
      // The latched request must not follow the client once granted.
      if (rand_en && m_busy && t_d) begin
         d_addr  = $urandom;
         d_wdata = $urandom;
      end
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 0;
      for (int k = 0; k < 400; k++) begin
         if (!m_busy && !m_gap && !i_read && !d_read && !d_write && !i_again && !d_again) begin
            done = 1;
            break;
         end
         step();
      end
      check_val({tag, "_drained"}, 32'(done), 32'h1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit reached;
      for (int k = 0; k < 64; k++) begin
         mem_model[k] = $urandom;
         mem_resp[k]  = mem_model[k];
      end
      mem_model[4] = 32'hDEADBEEF;
      mem_resp[4]  = 32'hDEADBEEF;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      ddr_bus.ddr_rdata = '0;
      rand_en = 0; spur_en = 0; hold_mode = 0;
      lat_min = 0; lat_max = 0; rsp_wait = 0;
      model_reset();

      // ---- reset values ----
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // ---- tie from reset: D, I, D ----
      hold_mode = 1;
      lat_min = 1; lat_max = 1;
      i_read = 1; i_addr = 32'h100;
      d_read = 1; d_addr = 32'h200;
      for (int k = 0; k < 60 && q_launch.size() < 3; k++) step();
      hold_mode = 0;
      drain("rr");
      check_val("rr_count", 32'(q_launch.size() >= 3), 32'h1);
      if (q_launch.size() >= 3) begin
         check_val("rr_grant0", q_launch[0], 32'h200);
         check_val("rr_grant1", q_launch[1], 32'h100);
         check_val("rr_grant2", q_launch[2], 32'h200);
      end

      // ---- single I read, zero-latency responder ----
      lat_min = 0; lat_max = 0;
      i_read = 1; i_addr = 32'h10;
      drain("iread");
      check_val("iread_rdata", i_rdata, 32'hDEADBEEF);

      // ---- D write then D read of an unaligned alias ----
      d_write = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
      drain("dwrite");
      d_read = 1; d_addr = 32'h22;
      drain("dread");
      check_val("dread_rdata", d_rdata, 32'h12345678);

      // ---- random traffic with address scrambling and stray ddr_resp ----
      rand_en = 1; spur_en = 1;
      lat_min = 0; lat_max = 5;
      repeat (2500) step();
      rand_en = 0; spur_en = 0;
      drain("random");

      // ---- stalled responder: timeout rises and sticks ----
      lat_min = 12; lat_max = 12;
      d_read = 1; d_addr = $urandom;
      drain("stall");
      repeat (3) step();
      check_val("timeout_sticky", 32'(ddr_timeout), 32'h1);

      // ---- asynchronous reset in the middle of REQ ----
      lat_min = 6; lat_max = 6;
      i_read = 1; i_addr = 32'h10;
      reached = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (m_busy) begin
            reached = 1;
            break;
         end
      end
      step();
      check_val("midreq_reached", 32'(reached && m_busy && ddr_bus.ddr_read), 32'h1);
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      model_reset();
      @(negedge clk);
      check_zero("held_rst");
      rst_n = 1'b1;

      lat_min = 0; lat_max = 2;
      i_read = 1; i_addr = 32'h10;
      drain("post_rst");
      check_val("post_rst_rdata", i_rdata, mem_model[4]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
